lenet_feeder: RTL

Reader side of the LeNet input buffer. The preprocessing core downsamples the centre of each camera frame into a 32x32-word buffer: the 28x28 image sits at word 66 + x + 32*y, with a 2-pixel border. On the core's `data_ready` pulse, this block reads the whole buffer in raster order and streams it to the CNN engine over a valid/ready interface. While it streams, it holds `busy` so the top level can block the next frame from overwriting the buffer mid-read.

---
 rtl/lenet_feeder_if.sv | 12 +
 rtl/lenet_feeder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/lenet_feeder_if.sv
// Pixel stream from lenet_feeder to the CNN engine: valid/ready plus a last-pixel tag.
interface lenet_feeder_if #(
  parameter int DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/lenet_feeder.sv
// Streams the LeNet input buffer in raster order on data_ready, holding busy until the last beat.
// Define LENET_FEEDER_PAD_ZERO_EN to emit border pixels as zero without reading them.
module lenet_feeder #(
  parameter int IMG_SIDE = 32,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int PAD      = 2
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              data_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  lenet_feeder_if.master    m,
  output logic              busy,
  output logic              overrun,
  input  logic              clear_overrun
);
  localparam int NPIX = IMG_SIDE * IMG_SIDE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] SIDE_M1   = ADDR_W'(IMG_SIDE - 1);
  localparam logic [ADDR_W-1:0] LO_EDGE   = ADDR_W'(PAD);
  localparam logic [ADDR_W-1:0] HI_EDGE   = ADDR_W'(IMG_SIDE - PAD);
`ifdef LENET_FEEDER_PAD_ZERO_EN
  localparam bit PadZero = 1'b1;
`else
  localparam bit PadZero = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q, col_q, row_q, rd_addr_q;
  logic              busy_q, ovr_q, rd_en_q;
  logic              slot_q, zero_q, slot_last_q;
  ent_t [1:0]        ent_q, ent_d;
  logic [1:0]        vld_q, vld_d;
  logic              pop, issue, border;
  logic [2:0]        credit;
  ent_t              new_ent;

  // A slot is a read (or a zero border entry) whose entry lands in the FIFO on the next edge,
  // so the credit is next-cycle occupancy and the FIFO can never exceed two entries.
  always_comb begin
    pop    = vld_q[0] & m.m_ready;
    credit = 3'(vld_q[0]) + 3'(vld_q[1]) + 3'(slot_q) - 3'(pop);
    issue  = (state_q == FETCH) && (credit < 3'd2);
    border = PadZero && ((col_q < LO_EDGE) || (col_q >= HI_EDGE) ||
                         (row_q < LO_EDGE) || (row_q >= HI_EDGE));
    new_ent.last = slot_last_q;
    new_ent.data = zero_q ? '0 : rd_data;
    ent_d = ent_q;
    vld_d = vld_q;
    if (pop) begin
      ent_d[0] = ent_q[1];
      vld_d    = {1'b0, vld_q[1]};
    end
    if (slot_q) begin
      if (!vld_d[0]) begin
        ent_d[0] = new_ent;
        vld_d[0] = 1'b1;
      end else begin
        ent_d[1] = new_ent;
        vld_d[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      slot_q      <= 1'b0;
      zero_q      <= 1'b0;
      slot_last_q <= 1'b0;
      ent_q       <= '0;
      vld_q       <= '0;
    end else begin
      slot_q      <= issue;
      zero_q      <= issue & border;
      slot_last_q <= issue && (ptr_q == LAST_ADDR);
      rd_en_q     <= issue & ~border;
      if (issue) rd_addr_q <= ptr_q;
      ent_q <= ent_d;
      vld_q <= vld_d;
      // A new overrun beats a simultaneous clear.
      if (data_ready && busy_q)  ovr_q <= 1'b1;
      else if (clear_overrun)    ovr_q <= 1'b0;
      unique case (state_q)
        IDLE: if (data_ready) begin
          state_q <= FETCH;
          busy_q  <= 1'b1;
          ptr_q   <= '0;
          col_q   <= '0;
          row_q   <= '0;
        end
        FETCH: if (issue) begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (col_q == SIDE_M1) begin
            col_q <= '0;
            row_q <= row_q + ADDR_W'(1);
          end else begin
            col_q <= col_q + ADDR_W'(1);
          end
          if (ptr_q == LAST_ADDR) state_q <= DRAIN;
        end
        DRAIN: if (pop && ent_q[0].last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign m.m_valid = vld_q[0];
  assign m.m_data  = ent_q[0].data;
  assign m.m_last  = ent_q[0].last;
  assign busy      = busy_q;
  assign overrun   = ovr_q;
endmodule
